// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_ctrl
//  Purpose  : Step-pattern sequencer for four active-low on-board LEDs.
//             Two active-low pushbuttons cycle through four patterns (mode)
//             and four step rates (speed). Contains its own base-tick
//             prescaler and a per-key synchroniser/debouncer.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    FPGA_CLK   in   1  system clock, rising edge
//    RST_N      in   1  synchronous active-low reset
//    KEY_MODE   in   1  raw pushbutton (active-low, asynchronous)
//    KEY_SPEED  in   1  raw pushbutton (active-low, asynchronous)
//    LED        out  4  registered LED drive, active-low (LED = ~pattern)
//    MODE       out  2  current pattern mode
//    SPEED      out  2  current step rate (steps every 8/4/2/1 base ticks)
//    STEP       out  1  one-cycle pulse in the cycle the pattern advances
// ============================================================================
module led_pattern_ctrl #(
    parameter int BASE_DIV     = 6250000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       FPGA_CLK,
    input  logic       RST_N,
    input  logic       KEY_MODE,
    input  logic       KEY_SPEED,
    output logic [3:0] LED,
    output logic [1:0] MODE,
    output logic [1:0] SPEED,
    output logic       STEP
);

    localparam int PRE_W = $clog2(BASE_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] MODE_WATER  = 2'd0;
    localparam logic [1:0] MODE_FILL   = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // ------------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------------
    logic [1:0] keys_raw;
    logic [1:0] press;      // [0] mode event, [1] speed event
    logic [1:0] boot;       // marks when the synchronisers carry real pin data

    assign keys_raw = {KEY_SPEED, KEY_MODE};

    always_ff @(posedge FPGA_CLK) begin
        if (!RST_N) begin
            boot <= 2'b00;
        end else begin
            boot <= {boot[0], 1'b1};
        end
    end

    generate
        for (genvar k = 0; k < 2; k++) begin : g_key
            logic            sync_a;
            logic            sync_b;
            logic            level;
            logic            level_d;
            logic            armed;
            logic            event_q;
            logic [DB_W-1:0] db_cnt;

            always_ff @(posedge FPGA_CLK) begin
                if (!RST_N) begin
                    sync_a  <= 1'b1;
                    sync_b  <= 1'b1;
                    level   <= 1'b1;
                    level_d <= 1'b1;
                    armed   <= 1'b0;
                    event_q <= 1'b0;
                    db_cnt  <= '0;
                end else begin
                    sync_a  <= keys_raw[k];
                    sync_b  <= sync_a;
                    level_d <= level;

                    if (sync_b == level) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        level  <= sync_b;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end

                    // A key already held through reset must be seen released
                    // before it can produce a press; arming waits until the
                    // synchronised pin (not the reset value) reads released.
                    armed   <= armed | (boot[1] & sync_b & level);
                    event_q <= armed & level_d & ~level;
                end
            end

            assign press[k] = event_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequencer: state register / next-state / outputs
    // ------------------------------------------------------------------------
    logic [1:0]       mode_q,  mode_n;
    logic [1:0]       speed_q, speed_n;
    logic [3:0]       pat_q,   pat_n;
    logic             dir_q,   dir_n;
    logic [PRE_W-1:0] pre_q,   pre_n;
    logic [2:0]       stp_q,   stp_n;
    logic [3:0]       led_q,   led_n;
    logic             step_q,  step_n;

    logic             tick;
    logic             step_fire;
    logic             any_ev;
    logic [2:0]       step_last;

    function automatic logic [3:0] init_pat(input logic [1:0] m);
        case (m)
            MODE_WATER:  init_pat = 4'b0001;
            MODE_FILL:   init_pat = 4'b0000;
            MODE_BLINK:  init_pat = 4'b1111;
            default:     init_pat = 4'b0001;
        endcase
    endfunction

    always_ff @(posedge FPGA_CLK) begin
        if (!RST_N) begin
            mode_q  <= MODE_WATER;
            speed_q <= 2'd0;
            pat_q   <= 4'b0001;
            dir_q   <= DIR_LEFT;
            pre_q   <= '0;
            stp_q   <= 3'd0;
            led_q   <= 4'b1110;
            step_q  <= 1'b0;
        end else begin
            mode_q  <= mode_n;
            speed_q <= speed_n;
            pat_q   <= pat_n;
            dir_q   <= dir_n;
            pre_q   <= pre_n;
            stp_q   <= stp_n;
            led_q   <= led_n;
            step_q  <= step_n;
        end
    end

    always_comb begin
        mode_n    = mode_q;
        speed_n   = speed_q;
        pat_n     = pat_q;
        dir_n     = dir_q;
        pre_n     = pre_q + PRE_W'(1);
        stp_n     = stp_q;
        any_ev    = press[0] | press[1];
        tick      = (pre_q == PRE_LAST);
        step_last = 3'd7 >> speed_q;        // (8 >> SPEED) - 1
        step_fire = tick && (stp_q == step_last);

        if (tick) begin
            pre_n = '0;
            stp_n = step_fire ? 3'd0 : stp_q + 3'd1;
        end

        // Any button event restarts the rate timing from zero.
        if (any_ev) begin
            pre_n = '0;
            stp_n = 3'd0;
        end

        if (press[1]) begin
            speed_n = speed_q + 2'd1;
        end

        if (press[0]) begin
            mode_n = mode_q + 2'd1;
            pat_n  = init_pat(mode_q + 2'd1);
            dir_n  = DIR_LEFT;
        end else if (step_fire && !press[1]) begin
            case (mode_q)
                MODE_WATER: pat_n = {pat_q[2:0], pat_q[3]};
                MODE_FILL: begin
                    case (pat_q)
                        4'b0000: pat_n = 4'b0001;
                        4'b0001: pat_n = 4'b0011;
                        4'b0011: pat_n = 4'b0111;
                        4'b0111: pat_n = 4'b1111;
                        default: pat_n = 4'b0000;
                    endcase
                end
                MODE_BLINK: pat_n = ~pat_q;
                default: begin
                    if (dir_q == DIR_LEFT) begin
                        if (pat_q == 4'b1000) begin
                            pat_n = 4'b0100;
                            dir_n = DIR_RIGHT;
                        end else begin
                            pat_n = {pat_q[2:0], 1'b0};
                        end
                    end else begin
                        if (pat_q == 4'b0001) begin
                            pat_n = 4'b0010;
                            dir_n = DIR_LEFT;
                        end else begin
                            pat_n = {1'b0, pat_q[3:1]};
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        led_n  = ~pat_n;
        step_n = step_fire & ~any_ev;
    end

    assign LED   = led_q;
    assign MODE  = mode_q;
    assign SPEED = speed_q;
    assign STEP  = step_q;

endmodule
`default_nettype wire
